sram_like_bus_arbiter: RTL and testbench

- Shares one SRAM-like master bus between the instruction-fetch port and the data-memory port of the pipeline.
- Sits between the core's `inst_*`/`data_*` SRAM-like interfaces and the single cache/bridge slave.
- Allows one transaction in flight at a time. Data has fixed priority by default.
- Latches the request fields at grant, so the master bus stays stable regardless of requester behaviour.

---
 rtl/sram_like_bus_arbiter_pkg.sv | 24 ++
 rtl/sram_like_bus_arbiter_if.sv | 25 ++
 rtl/sram_like_bus_arbiter_arb_pick.sv | 43 ++++
 rtl/sram_like_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_like_bus_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_bus_arbiter_pkg.sv
// Shared definitions for the SRAM-like bus arbiter: FSM states, owner codes
// and the request-field bundle used both for the grant mux and the latch.
package cpu_defs;

    localparam int CPU_ADDR_W = 32;
    localparam int CPU_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef struct packed {
        logic                  wr;
        logic [1:0]            size;
        logic [CPU_ADDR_W-1:0] addr;
        logic [CPU_DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_like_bus_arbiter_if.sv
// SRAM-like request/response bundle. "master" drives the request side,
// "slave" answers with addr_ok/data_ok/rdata.
interface sram_like_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_bus_arbiter_arb_pick.sv
// Grant selector for the arbiter. Fixed data-over-inst priority unless
// ARB_ROUND_ROBIN_EN is defined, which adds a last-owner register for ties.
module arb_pick
    import cpu_defs::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic arb_en,
    input  logic inst_req,
    input  logic data_req,
    output logic grant_valid,
    output logic grant_owner
);

    assign grant_valid = arb_en & (inst_req | data_req);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q;
    logic last_owner_d;

    always_comb begin
        grant_owner  = data_req ? OWN_DATA : OWN_INST;
        // On a tie, hand the bus to whichever port sat out the last transfer.
        if (inst_req && data_req) begin
            grant_owner = ~last_owner_q;
        end
        last_owner_d = grant_valid ? grant_owner : last_owner_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= OWN_DATA;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    assign grant_owner = data_req ? OWN_DATA : OWN_INST;
`endif

endmodule

// File: rtl/sram_like_bus_arbiter.sv
// Shares one SRAM-like master bus between the inst and data ports, one transfer
// in flight at a time. Optional ARB_ROUND_ROBIN_EN switches ties to round-robin.
module sram_like_bus_arbiter
    import cpu_defs::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_like_bus_arbiter_if.slave  inst_bus,
    sram_like_bus_arbiter_if.slave  data_bus,
    sram_like_bus_arbiter_if.master m_bus,
    output logic                    owner,
    output logic                    busy,
    output logic                    proto_err
);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              proto_err_q, proto_err_d;
    sram_req_t         req_q, req_d;
    sram_req_t         inst_fields, data_fields;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              grant_valid, grant_owner;
    logic              addr_ok_fwd, data_ok_fwd;

    assign inst_fields = '{wr: inst_bus.wr, size: inst_bus.size,
                           addr: CPU_ADDR_W'(inst_bus.addr), wdata: CPU_DATA_W'(inst_bus.wdata)};
    assign data_fields = '{wr: data_bus.wr, size: data_bus.size,
                           addr: CPU_ADDR_W'(data_bus.addr), wdata: CPU_DATA_W'(data_bus.wdata)};

    arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
        .clk         (clk),
        .rst         (rst),
`endif
        .arb_en      (state_q == IDLE),
        .inst_req    (inst_bus.req),
        .data_req    (data_bus.req),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        req_d        = req_q;
        proto_err_d  = proto_err_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        addr_ok_fwd  = 1'b0;
        data_ok_fwd  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_owner;
                    req_d   = (grant_owner == OWN_DATA) ? data_fields : inst_fields;
                    state_d = ADDR;
                end
                if (m_bus.data_ok) begin
                    proto_err_d = 1'b1;
                end
            end
            ADDR: begin
                addr_ok_fwd = m_bus.addr_ok;
                if (m_bus.addr_ok) begin
                    data_ok_fwd = m_bus.data_ok;
                    state_d     = m_bus.data_ok ? IDLE : DATA;
                end else if (m_bus.data_ok) begin
                    // A response before the address was taken cannot belong to us.
                    proto_err_d = 1'b1;
                end
            end
            DATA: begin
                if (m_bus.data_ok) begin
                    data_ok_fwd = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (data_ok_fwd) begin
            if (owner_q == OWN_DATA) begin
                data_rdata_d = m_bus.rdata;
            end else begin
                inst_rdata_d = m_bus.rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INST;
            proto_err_q  <= 1'b0;
            req_q        <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            proto_err_q  <= proto_err_d;
            req_q        <= req_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign m_bus.req   = (state_q == ADDR);
    assign m_bus.wr    = req_q.wr;
    assign m_bus.size  = req_q.size;
    assign m_bus.addr  = req_q.addr[ADDR_W-1:0];
    assign m_bus.wdata = req_q.wdata[DATA_W-1:0];

    assign inst_bus.addr_ok = addr_ok_fwd & (owner_q == OWN_INST);
    assign data_bus.addr_ok = addr_ok_fwd & (owner_q == OWN_DATA);
    assign inst_bus.data_ok = data_ok_fwd & (owner_q == OWN_INST);
    assign data_bus.data_ok = data_ok_fwd & (owner_q == OWN_DATA);
    assign inst_bus.rdata   = inst_bus.data_ok ? m_bus.rdata : inst_rdata_q;
    assign data_bus.rdata   = data_bus.data_ok ? m_bus.rdata : data_rdata_q;

    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sram_like_bus_arbiter.sv
// Directed bench for sram_like_bus_arbiter: transaction-level model checked every
// cycle plus hand-computed expectations from the test plan.
`timescale 1ns/1ps
module tb_sram_like_bus_arbiter;
    import cpu_defs::*;

    logic clk = 1'b0;
    logic rst;
    logic owner, busy, proto_err;

    sram_like_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
    sram_like_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
    sram_like_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

    sram_like_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_bus  (inst_if),
        .data_bus  (data_if),
        .m_bus     (m_if),
        .owner     (owner),
        .busy      (busy),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit        mb_busy, mb_acc, mb_own, mb_perr, mb_last;
    sram_req_t mb_req;
    logic [31:0] mb_rd_i, mb_rd_d;

    always @(negedge clk) begin
        logic e_mreq, aok, dok, own;
        if (rst) begin
            mb_busy = 0; mb_acc = 0; mb_own = 0; mb_perr = 0; mb_last = 1;
            mb_req = '0; mb_rd_i = '0; mb_rd_d = '0;
        end
        e_mreq = mb_busy && !mb_acc;
        aok    = e_mreq && m_if.addr_ok;
        dok    = mb_busy && m_if.data_ok && (mb_acc || m_if.addr_ok);

        chk("m_req", m_if.req, e_mreq);
        chk("m_wr", m_if.wr, mb_req.wr);
        chk("m_size", m_if.size, mb_req.size);
        chk("m_addr", m_if.addr, mb_req.addr);
        chk("m_wdata", m_if.wdata, mb_req.wdata);
        chk("owner", owner, mb_own);
        chk("busy", busy, mb_busy);
        chk("proto_err", proto_err, mb_perr);
        chk("inst_addr_ok", inst_if.addr_ok, aok && !mb_own);
        chk("data_addr_ok", data_if.addr_ok, aok && mb_own);
        chk("inst_data_ok", inst_if.data_ok, dok && !mb_own);
        chk("data_data_ok", data_if.data_ok, dok && mb_own);
        chk("inst_rdata", inst_if.rdata, (dok && !mb_own) ? m_if.rdata : mb_rd_i);
        chk("data_rdata", data_if.rdata, (dok && mb_own) ? m_if.rdata : mb_rd_d);

        if (!rst) begin
            if (!mb_busy) begin
                if (m_if.data_ok) mb_perr = 1;
                if (inst_if.req || data_if.req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    own = (inst_if.req && data_if.req) ? !mb_last : data_if.req;
`else
                    own = data_if.req;
`endif
                    mb_last = own;
                    mb_own  = own;
                    mb_busy = 1;
                    mb_acc  = 0;
                    mb_req  = own ? '{wr: data_if.wr, size: data_if.size, addr: data_if.addr, wdata: data_if.wdata}
                                  : '{wr: inst_if.wr, size: inst_if.size, addr: inst_if.addr, wdata: inst_if.wdata};
                end
            end else if (!mb_acc && !m_if.addr_ok) begin
                if (m_if.data_ok) mb_perr = 1;
            end else if (dok) begin
                mb_busy = 0;
                if (mb_own) mb_rd_d = m_if.rdata; else mb_rd_i = m_if.rdata;
                $display("txn cycle %0d owner=%0d wr=%0d addr=%h wdata=%h rdata=%h",
                         cycle, mb_own, mb_req.wr, mb_req.addr, mb_req.wdata, m_if.rdata);
            end else begin
                mb_acc = 1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic advance();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    bit exp_own [6];

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_own = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        rst = 1'b0;
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = 0; inst_if.addr = 0; inst_if.wdata = 0;
        data_if.req = 0; data_if.wr = 0; data_if.size = 0; data_if.addr = 0; data_if.wdata = 0;
        m_if.addr_ok = 0; m_if.data_ok = 0; m_if.rdata = 0;
        #1 rst = 1'b1;
        sample();
        chk("rst_m_req", m_if.req, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_proto_err", proto_err, 1'b0);
        advance();
        advance();
        rst = 1'b0;
        advance();

        // single inst read
        inst_if.req = 1; inst_if.addr = 32'hBFC0_0000; inst_if.size = 2;
        sample(); chk("t1_busy_c0", busy, 1'b0); advance();
        inst_if.req = 0;
        sample(); chk("t1_m_addr_c1", m_if.addr, 32'hBFC0_0000); chk("t1_m_req_c1", m_if.req, 1'b1); advance();
        m_if.addr_ok = 1;
        sample(); chk("t1_inst_addr_ok_c2", inst_if.addr_ok, 1'b1); chk("t1_data_addr_ok_c2", data_if.addr_ok, 1'b0); advance();
        m_if.addr_ok = 0;
        sample(); chk("t1_m_req_c3", m_if.req, 1'b0); advance();
        m_if.data_ok = 1; m_if.rdata = 32'h3C1D_0000;
        sample(); chk("t1_inst_data_ok_c4", inst_if.data_ok, 1'b1); chk("t1_inst_rdata_c4", inst_if.rdata, 32'h3C1D_0000);
        chk("t1_data_data_ok_c4", data_if.data_ok, 1'b0); advance();
        m_if.data_ok = 0; m_if.rdata = 0;

        // simultaneous requests: data wins
        inst_if.req = 1; inst_if.addr = 32'hBFC0_0004;
        data_if.req = 1; data_if.wr = 1; data_if.size = 2; data_if.addr = 32'h8000_0010; data_if.wdata = 32'h1234_5678;
        sample(); chk("t1_inst_rdata_hold", inst_if.rdata, 32'h3C1D_0000); advance();
        m_if.addr_ok = 1;
        sample(); chk("t2_m_wr", m_if.wr, 1'b1); chk("t2_m_addr", m_if.addr, 32'h8000_0010);
        chk("t2_owner", owner, 1'b1); advance();
        m_if.addr_ok = 0; m_if.data_ok = 1; data_if.req = 0; data_if.wr = 0;
        sample(); chk("t2_data_data_ok", data_if.data_ok, 1'b1); chk("t2_inst_data_ok", inst_if.data_ok, 1'b0); advance();
        m_if.data_ok = 0;
        sample(); chk("t2_idle_gap", busy, 1'b0); advance();

        // same-cycle handshakes on the inst grant
        m_if.addr_ok = 1; m_if.data_ok = 1; m_if.rdata = 32'hAAAA_5555; inst_if.addr = 32'hBFC0_0008;
        sample(); chk("t3_owner", owner, 1'b0); chk("t3_m_addr", m_if.addr, 32'hBFC0_0004);
        chk("t3_inst_addr_ok", inst_if.addr_ok, 1'b1); chk("t3_inst_data_ok", inst_if.data_ok, 1'b1);
        chk("t3_inst_rdata", inst_if.rdata, 32'hAAAA_5555); advance();
        m_if.addr_ok = 0; m_if.data_ok = 0; m_if.rdata = 0;
        sample(); chk("t3_idle_after", busy, 1'b0); chk("t3_m_req_idle", m_if.req, 1'b0); advance();

        // requester drops and scribbles its address while in ADDR
        inst_if.req = 0; inst_if.addr = 32'h0;
        sample(); chk("t4_m_req", m_if.req, 1'b1); chk("t4_m_addr_c6", m_if.addr, 32'hBFC0_0008); advance();
        m_if.addr_ok = 1;
        sample(); chk("t4_m_addr_c7", m_if.addr, 32'hBFC0_0008); chk("t4_inst_addr_ok", inst_if.addr_ok, 1'b1); advance();
        m_if.addr_ok = 0; m_if.data_ok = 1; m_if.rdata = 32'h0BAD_F00D;
        sample(); chk("t4_inst_rdata", inst_if.rdata, 32'h0BAD_F00D); advance();
        m_if.data_ok = 0; m_if.rdata = 0;
        sample(); chk("t4_inst_rdata_hold", inst_if.rdata, 32'h0BAD_F00D); advance();

        // stray response in IDLE
        m_if.data_ok = 1; m_if.rdata = 32'hDEAD_BEEF;
        sample(); chk("t5_stray_inst_ok", inst_if.data_ok, 1'b0); chk("t5_stray_data_ok", data_if.data_ok, 1'b0);
        chk("t5_stray_rdata", inst_if.rdata, 32'h0BAD_F00D); advance();
        m_if.data_ok = 0; m_if.rdata = 0;
        data_if.req = 1; data_if.addr = 32'h8000_0040;
        sample(); chk("t5_proto_err_set", proto_err, 1'b1); advance();
        data_if.req = 0; m_if.addr_ok = 1;
        sample(); chk("t5_data_addr_ok", data_if.addr_ok, 1'b1); advance();
        m_if.addr_ok = 0; rst = 1'b1;
        sample(); chk("t5_rst_busy", busy, 1'b0); chk("t5_rst_m_addr", m_if.addr, 32'h0);
        chk("t5_rst_proto_err", proto_err, 1'b0); chk("t5_rst_owner", owner, 1'b0); advance();
        rst = 1'b0;
        sample(); advance();
        m_if.data_ok = 1; m_if.rdata = 32'h1111_1111;
        sample(); chk("t5_late_data_ok", data_if.data_ok, 1'b0); advance();
        m_if.data_ok = 0; m_if.rdata = 0;
        sample(); chk("t5_late_proto_err", proto_err, 1'b1); chk("t5_late_rdata", data_if.rdata, 32'h0); advance();

        // continuous contention: owner sequence
        inst_if.req = 1; inst_if.addr = 32'hBFC0_0100;
        data_if.req = 1; data_if.addr = 32'h8000_0100;
        for (int k = 0; k < 6; k++) begin
            sample(); advance();
            m_if.addr_ok = 1;
            sample(); chk($sformatf("t6_owner_%0d", k), owner, exp_own[k]); advance();
            m_if.addr_ok = 0; m_if.data_ok = 1; m_if.rdata = 32'h5000_0000 + k;
            sample(); advance();
            m_if.data_ok = 0; m_if.rdata = 0;
        end
        inst_if.req = 0; data_if.req = 0;
        repeat (3) begin sample(); advance(); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
